// File: rtl/rr_arbiter_8_if.sv
// Request/grant bundle between the requesters and the round-robin arbiter.
// Also carries debug copies of the arbiter's FSM state and rotation pointer.
interface rr_arbiter_8_if;
  // Handshake: i_req[i] is a level-sensitive request. o_grant[i] high means
  // requester i owns the resource. Ownership lasts until the owner pulses
  // i_release, drops i_req[i], or the hold timeout expires. o_timeout_flag
  // marks the cycle after a grant was revoked by timeout.
  logic [7:0] i_req;
  logic       i_release;
  logic [7:0] o_grant;
  logic [2:0] o_grant_idx;
  logic       o_busy;
  logic       o_timeout_flag;
  logic       o_dbg_state;
  logic [2:0] o_dbg_ptr;

  modport master (
    output i_req, i_release,
    input  o_grant, o_grant_idx, o_busy, o_timeout_flag, o_dbg_state, o_dbg_ptr
  );

  modport slave (
    input  i_req, i_release,
    output o_grant, o_grant_idx, o_busy, o_timeout_flag, o_dbg_state, o_dbg_ptr
  );
endinterface

// File: rtl/rr_arbiter_8.sv
// Eight-way round-robin arbiter with hold-until-release grants and an optional
// hold timeout. Grant vector and binary index are both registered.
module rr_arbiter_8 #(
  parameter int TIMEOUT   = 16,
  parameter int PTR_RESET = 0
) (
  input logic           i_clk,
  input logic           i_rst,
  rr_arbiter_8_if.slave bus
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  localparam logic [2:0] PTR_INIT = 3'(PTR_RESET);
  localparam bit         TO_EN    = (TIMEOUT != 0);
  localparam logic [7:0] TO_LAST  = (TIMEOUT == 0) ? 8'd0 : 8'(TIMEOUT - 1);

  state_t     r_state;
  logic [2:0] r_ptr;
  logic [7:0] r_hold_cnt;
  logic [7:0] r_grant;
  logic [2:0] r_idx;
  logic       r_busy;
  logic       r_timeout;

  logic       w_found;
  logic [2:0] w_winner;
  logic [2:0] w_cand;
  logic       w_drop;
  logic       w_expire;
  logic       w_end;
  logic       w_to_end;

  // Scan requesters starting at the pointer; the first set bit wins.
  always_comb begin
    w_found  = 1'b0;
    w_winner = 3'd0;
    w_cand   = 3'd0;
    for (int k = 0; k < 8; k++) begin
      w_cand = r_ptr + 3'(k);
      if (!w_found && bus.i_req[w_cand]) begin
        w_found  = 1'b1;
        w_winner = w_cand;
      end
    end
  end

  // Release beats request drop, which beats timeout.
  assign w_drop   = ~bus.i_req[r_idx];
  assign w_expire = TO_EN && (r_hold_cnt == TO_LAST);
  assign w_end    = bus.i_release | w_drop | w_expire;
  assign w_to_end = w_expire & ~bus.i_release & ~w_drop;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_ptr      <= PTR_INIT;
      r_hold_cnt <= 8'd0;
      r_grant    <= 8'd0;
      r_idx      <= 3'd0;
      r_busy     <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_grant    <= 8'd1 << w_winner;
            r_idx      <= w_winner;
            r_busy     <= 1'b1;
            r_hold_cnt <= 8'd0;
            r_state    <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (w_end) begin
            r_grant   <= 8'd0;
            r_idx     <= 3'd0;
            r_busy    <= 1'b0;
            r_ptr     <= r_idx + 3'd1;
            r_timeout <= w_to_end;
            r_state   <= ST_IDLE;
          end else if (r_hold_cnt != 8'hFF) begin
            r_hold_cnt <= r_hold_cnt + 8'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.o_grant        = r_grant;
  assign bus.o_grant_idx    = r_idx;
  assign bus.o_busy         = r_busy;
  assign bus.o_timeout_flag = r_timeout;
  assign bus.o_dbg_state    = r_state;
  assign bus.o_dbg_ptr      = r_ptr;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Self-checking bench for rr_arbiter_8: directed scenarios followed by random
// requests, checked cycle by cycle against an ownership-level reference model.
module tb_rr_arbiter_8;

  localparam int TO = 4;
  localparam int PR = 0;
  localparam int W  = 16;

  logic clk;
  logic rst;
  rr_arbiter_8_if bus ();

  rr_arbiter_8 #(.TIMEOUT(TO), .PTR_RESET(PR)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];

  // reference model: who owns the resource and for how many cycles so far
  int m_busy, m_owner, m_cycles, m_ptr, m_to;

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_cycles = 0; m_ptr = PR; m_to = 0;
  endtask

  task automatic model_step(input logic [7:0] rq, input logic rl);
    bit ended, expired;
    m_to = 0;
    if (m_busy == 0) begin
      for (int k = 0; k < 8; k++) begin
        if (rq[(m_ptr + k) % 8]) begin
          m_owner  = (m_ptr + k) % 8;
          m_busy   = 1;
          m_cycles = 1;
          break;
        end
      end
    end else begin
      ended   = rl || !rq[m_owner];
      expired = (TO != 0) && (m_cycles >= TO);
      if (ended || expired) begin
        m_to   = ended ? 0 : 1;
        m_busy = 0;
        m_ptr  = (m_owner + 1) % 8;
      end else begin
        m_cycles++;
      end
    end
  endtask

  function automatic logic [W-1:0] model_pack();
    logic [7:0] g;
    logic [2:0] ix;
    g  = (m_busy != 0) ? (8'd1 << m_owner) : 8'd0;
    ix = (m_busy != 0) ? 3'(m_owner) : 3'd0;
    return {3'(m_ptr), 1'(m_to), 1'(m_busy), ix, g};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // driver: inputs change at the falling edge, expectation for the next rise queued
  task automatic step(input logic r, input logic [7:0] rq, input logic rl);
    @(negedge clk);
    rst           = r;
    bus.i_req     = rq;
    bus.i_release = rl;
    if (r) model_reset();
    else   model_step(rq, rl);
    exp_q.push_back(model_pack());
  endtask

  // monitor: compare every registered output after each rising edge
  always @(posedge clk) begin
    logic [W-1:0] e;
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("grant",     {24'd0, bus.o_grant},          {24'd0, e[7:0]});
      chk("grant_idx", {29'd0, bus.o_grant_idx},      {29'd0, e[10:8]});
      chk("busy",      {31'd0, bus.o_busy},           {31'd0, e[11]});
      chk("state",     {31'd0, bus.o_dbg_state},      {31'd0, e[11]});
      chk("timeout",   {31'd0, bus.o_timeout_flag},   {31'd0, e[12]});
      chk("ptr",       {29'd0, bus.o_dbg_ptr},        {29'd0, e[15:13]});
    end
  end

  initial begin
    #2_000_000;
    bad++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] rq;
    logic       rl;
    rst = 1'b1; bus.i_req = 8'hFF; bus.i_release = 1'b0;
    model_reset();

    // T1 reset with all requesting
    step(1'b1, 8'hFF, 1'b0);
    step(1'b1, 8'hFF, 1'b1);
    @(posedge clk); #2;
    chk("t1_rst_grant", {24'd0, bus.o_grant}, 32'd0);
    chk("t1_rst_busy",  {31'd0, bus.o_busy},  32'd0);
    step(1'b0, 8'hFF, 1'b0);
    @(posedge clk); #2;
    chk("t1_first_grant", {24'd0, bus.o_grant}, 32'h01);

    // T2 rotation with release pulsed each grant
    for (int g = 0; g < 9; g++) begin
      step(1'b0, 8'hFF, 1'b1);
      step(1'b0, 8'hFF, 1'b0);
    end

    // T3 pointer at 6, wrap and skip
    step(1'b0, 8'h20, 1'b1);
    step(1'b0, 8'h20, 1'b0);
    step(1'b0, 8'h20, 1'b1);
    for (int g = 0; g < 3; g++) begin
      step(1'b0, 8'h05, 1'b0);
      step(1'b0, 8'h05, 1'b0);
      step(1'b0, 8'h05, 1'b1);
    end
    step(1'b0, 8'h00, 1'b0);

    // T4 timeout with a lone requester
    for (int c = 0; c < 6; c++) step(1'b0, 8'h10, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0);

    // T5 request drop
    step(1'b0, 8'h08, 1'b0);
    step(1'b0, 8'h08, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0);

    // T6 async reset between edges while granting
    step(1'b0, 8'hC0, 1'b0);
    step(1'b0, 8'hC0, 1'b0);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("t6_async_grant", {24'd0, bus.o_grant},   32'd0);
    chk("t6_async_busy",  {31'd0, bus.o_busy},    32'd0);
    chk("t6_async_ptr",   {29'd0, bus.o_dbg_ptr}, PR);
    step(1'b1, 8'hC0, 1'b0);
    step(1'b0, 8'hC0, 1'b0);
    step(1'b0, 8'hC0, 1'b1);

    // random phase
    rq = 8'h00;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 3))
          0: rq = 8'h00;
          1: rq = 8'd1 << $urandom_range(0, 7);
          default: rq = 8'($urandom);
        endcase
      end
      rl = ($urandom_range(0, 5) == 0);
      step(1'b0, rq, rl);
    end
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);

    repeat (3) @(negedge clk);
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
